// File: rtl/low_pass_filter.sv
// low_pass_filter: streaming moving-average filter over the most recent
// 2^LOG2_TAPS signed samples. One sample per clock, one register of latency.
// Optional build macro LPF_ROUND_EN switches the output from floor to
// round-half-up; the running sum itself is identical in both builds.
module low_pass_filter #(
  parameter int DATA_W    = 32,
  parameter int LOG2_TAPS = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] noisy_data,
  output logic [DATA_W-1:0] filtered_data
);

  localparam int TAPS  = 1 << LOG2_TAPS;
  localparam int ACC_W = DATA_W + LOG2_TAPS;

  // dl_q[0] is x[n-1], dl_q[TAPS-1] is x[n-N] (the sample about to leave)
  logic [DATA_W-1:0]       dl_q [TAPS];
  logic [DATA_W-1:0]       dl_d [TAPS];
  logic signed [ACC_W-1:0] sum_q, sum_d;
  logic signed [ACC_W-1:0] rnd;
  logic [DATA_W-1:0]       out_q, out_d;
  logic [LOG2_TAPS-1:0]    frac_unused;

  // Running sum update, delay-line shift and scaled output
  always_comb begin
    sum_d = sum_q
          + {{LOG2_TAPS{noisy_data[DATA_W-1]}}, noisy_data}
          - {{LOG2_TAPS{dl_q[TAPS-1][DATA_W-1]}}, dl_q[TAPS-1]};
    dl_d[0] = noisy_data;
    for (int i = 1; i < TAPS; i++) dl_d[i] = dl_q[i-1];
`ifdef LPF_ROUND_EN
    // Half an LSB of the output before the shift gives round-half-up;
    // cannot overflow since |sum| <= N*2^(DATA_W-1) leaves headroom of N-1.
    rnd = sum_d + ACC_W'(TAPS / 2);
`else
    rnd = sum_d;
`endif
    // Arithmetic shift right by LOG2_TAPS, truncated to DATA_W: the top
    // DATA_W bits of the accumulator; the mean always fits, so no wrap.
    out_d       = rnd[ACC_W-1:LOG2_TAPS];
    frac_unused = rnd[LOG2_TAPS-1:0];
  end

  // State registers; reset holds the window, sum and output at zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q <= '0;
      out_q <= '0;
      for (int i = 0; i < TAPS; i++) dl_q[i] <= '0;
    end else begin
      sum_q <= sum_d;
      out_q <= out_d;
      for (int i = 0; i < TAPS; i++) dl_q[i] <= dl_d[i];
    end
  end

  assign filtered_data = out_q;

endmodule

// File: tb/tb_low_pass_filter.sv
// Self-checking bench for low_pass_filter (DATA_W=32, LOG2_TAPS=3).
// A behavioural window model produces the expected value for every driven
// sample; expectations are queued at drive time and popped after the edge.
module tb_low_pass_filter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] noisy_data = '0;
  logic [31:0] filtered_data;

  int total = 0;
  int bad   = 0;

  logic signed [31:0] win [$];
  logic [31:0]        sb  [$];

  low_pass_filter #(.DATA_W(32), .LOG2_TAPS(3)) dut (
    .clk(clk), .reset(reset), .noisy_data(noisy_data),
    .filtered_data(filtered_data)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    win.delete();
    for (int i = 0; i < 8; i++) win.push_back(32'sd0);
  endtask

  // Mean of the newest 8 samples after inserting s
  function automatic logic [31:0] model_push(input logic [31:0] s);
    longint acc;
    longint q;
    logic [63:0] qv;
    win.push_front(s);
    void'(win.pop_back());
    acc = 0;
    foreach (win[i]) acc += longint'(win[i]);
`ifdef LPF_ROUND_EN
    acc += 4;
`endif
    q  = acc >>> 3;
    qv = q;
    return qv[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] exp);
    total++;
    assert (filtered_data === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, filtered_data, exp);
    end
  endtask

  // Drive one sample, let the edge happen, compare against the queued model
  task automatic step(input string tag, input logic [31:0] s);
    logic [31:0] e;
    noisy_data = s;
    sb.push_back(model_push(s));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check(tag, e);
  endtask

  // Short async reset pulse between edges; output must clear immediately
  task automatic pulse_reset(input string tag);
    reset = 1'b0;
    #1;
    check(tag, 32'h0);
    model_clear();
    #1;
    reset = 1'b1;
  endtask

  logic [31:0] rnd5 [8];

  initial begin
`ifdef LPF_ROUND_EN
    rnd5 = '{32'd1, 32'd1, 32'd2, 32'd3, 32'd3, 32'd4, 32'd4, 32'd5};
`else
    rnd5 = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd3, 32'd3, 32'd4, 32'd5};
`endif
    model_clear();

    // Held in reset with toggling input: output stays 0
    #2;
    for (int i = 0; i < 4; i++) begin
      noisy_data = 32'hDEAD_0000 ^ 32'(i * 32'h1357);
      @(posedge clk);
      #1;
      check("reset_hold", 32'h0);
    end
    reset = 1'b1;

    // Step of 0x800: ramp 0x100..0x800, then steady
    for (int k = 1; k <= 11; k++) begin
      step("step", 32'h800);
      check("step_const", (k < 8) ? 32'(k * 32'h100) : 32'h800);
    end

    // Mid-stream reset: 4 samples, async clear, ramp restarts at 0x100
    pulse_reset("rst_a");
    for (int k = 0; k < 4; k++) step("pre_rst", 32'h800);
    pulse_reset("mid_rst_async");
    step("post_rst", 32'h800);
    check("post_rst_const", 32'h100);
    step("post_rst", 32'h800);
    check("post_rst_const2", 32'h200);

    // Impulse: 0x10 for exactly 8 edges, then 0
    pulse_reset("rst_b");
    step("impulse", 32'h80);
    check("impulse_const", 32'h10);
    for (int k = 1; k < 12; k++) begin
      step("impulse", 32'h0);
      check("impulse_const", (k < 8) ? 32'h10 : 32'h0);
    end

    // Rounding behaviour on constant 5
    pulse_reset("rst_c");
    for (int k = 0; k < 8; k++) begin
      step("round5", 32'd5);
      check("round5_const", rnd5[k]);
    end

    // Extremes: positive max and negative min settle without wrap
    pulse_reset("rst_d");
    for (int k = 0; k < 10; k++) step("max_pos", 32'h7FFF_FFFF);
    check("max_pos_settle", 32'h7FFF_FFFF);
    pulse_reset("rst_e");
    for (int k = 0; k < 10; k++) step("max_neg", 32'h8000_0000);
    check("max_neg_settle", 32'h8000_0000);

    // Constant -8: -1..-8
    pulse_reset("rst_f");
    for (int k = 1; k <= 8; k++) begin
      step("neg8", 32'hFFFF_FFF8);
      check("neg8_const", 32'(-k));
    end

    // Random mixed-sign traffic against the model
    pulse_reset("rst_g");
    for (int k = 0; k < 60; k++) step("random", $urandom);

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
